// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: FSM states,
// exception cause codes and instruction size.
package cpu_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    EXCEPT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ALIGN       = 2'd0,
    BUS_TIMEOUT = 2'd1,
    ILLEGAL     = 2'd2,
    OVERFLOW    = 2'd3
  } cause_e;

  localparam int INSN_BYTES = 4;
  localparam int WAIT_CNT_W = 8;
endpackage

// File: rtl/wait_timer.sv
// Memory wait-cycle counter; terminal flags the last cycle a fetch may wait.
module wait_timer
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic terminal
);
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + WAIT_CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign terminal = (cnt_q == WAIT_CNT_W'(MAX_WAIT));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: fetch with bus timeout, one-cycle decode strobe,
// execute with branch/overflow handling and a single-cycle exception state.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_00FF),
  parameter int               MAX_WAIT     = 15
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      ir,
  output logic             decode_valid,
  input  logic             illegal_op,
  input  logic             exec_done,
  input  logic             overflow,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       cause,
  output logic             exc_pulse,
  output logic [WIDTH-1:0] retired,
  output logic [2:0]       state
);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSN_BYTES);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, retired_q, retired_d;
  logic [31:0]      ir_q, ir_d;
  cause_e           cause_q, cause_d;
  logic             timeout, misaligned;

  assign misaligned = |branch_target[1:0];

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clr      (state_q == FETCH),
    .inc      (state_q == WAIT && !mem_ready && !timeout),
    .terminal (timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = WAIT;
      WAIT:   if (mem_ready) state_d = DECODE;
              else if (timeout) state_d = EXCEPT;
      DECODE: state_d = illegal_op ? EXCEPT : EXEC;
      EXEC:   if (exec_done)
                state_d = (overflow || (branch_taken && misaligned)) ? EXCEPT : FETCH;
      EXCEPT: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    mem_req      = (state_q == FETCH) || (state_q == WAIT);
    mem_addr     = pc_q;
    decode_valid = (state_q == DECODE);
    exc_pulse    = (state_q == EXCEPT);
  end

  // epc/cause are captured on entry to EXCEPT so they are valid alongside exc_pulse.
  // pc has already advanced past the faulting word except on a bus timeout.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    case (state_q)
      WAIT:
        if (mem_ready) begin
          ir_d = mem_rdata;
          pc_d = pc_q + STEP;
        end else if (timeout) begin
          epc_d   = pc_q;
          cause_d = BUS_TIMEOUT;
        end
      DECODE:
        if (illegal_op) begin
          epc_d   = pc_q - STEP;
          cause_d = ILLEGAL;
        end
      EXEC:
        if (exec_done) begin
          if (overflow) begin
            epc_d   = pc_q - STEP;
            cause_d = OVERFLOW;
          end else if (branch_taken && misaligned) begin
            epc_d   = pc_q - STEP;
            cause_d = ALIGN;
          end else begin
            retired_d = retired_q + WIDTH'(1);
            if (branch_taken) pc_d = branch_target;
          end
        end
      EXCEPT: pc_d = EXC_VECTOR;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      epc_q     <= '0;
      cause_q   <= ALIGN;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign epc     = epc_q;
  assign cause   = cause_q;
  assign retired = retired_q;
  assign state   = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a per-instruction model.
module tb_fetch_sequencer;
  import cpu_pkg::*;
  localparam int          MW  = 15;
  localparam logic [31:0] EXC = 32'h0000_00FF;

  logic        clock = 1'b0, reset = 1'b1;
  logic        mem_req, mem_ready, decode_valid, illegal_op, exec_done, overflow;
  logic        branch_taken, exc_pulse;
  logic [31:0] mem_addr, mem_rdata, ir, branch_target, pc, epc, retired;
  logic [1:0]  cause;
  logic [2:0]  state;

  fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir), .decode_valid(decode_valid),
    .illegal_op(illegal_op), .exec_done(exec_done), .overflow(overflow),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc), .epc(epc),
    .cause(cause), .exc_pulse(exc_pulse), .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_fail = 0;
  longint      cyc = 0;
  logic [31:0] m_pc, m_ret, m_epc;
  logic [1:0]  m_cause;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_pc = 32'h0; m_ret = 0; m_epc = 0; m_cause = 0;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    model_reset();
  endtask

  // Drives one instruction from FETCH to the next FETCH; lat > MW forces a bus timeout.
  task automatic run_instr(input int lat, input bit ill, input bit ovf, input bit br,
                           input logic [31:0] tgt, input int elat);
    logic [31:0] word;
    bit exc;
    word = $urandom;
    n_chk++;
    if (state !== FETCH || mem_req !== 1'b1 || mem_addr !== m_pc || decode_valid !== 1'b0 || exc_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch: state=%0d req=%b addr=%h, required state=0 req=1 addr=%h", state, mem_req, mem_addr, m_pc);
    end
    mem_ready = 1'($urandom); illegal_op = 1'($urandom); exec_done = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clock);
    for (int k = 0; k <= MW; k++) begin
      n_chk++;
      if (state !== WAIT || mem_req !== 1'b1 || mem_addr !== m_pc || exc_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL wait[%0d]: state=%0d req=%b addr=%h, required state=1 req=1 addr=%h", k, state, mem_req, mem_addr, m_pc);
      end
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? word : $urandom;
      illegal_op = 1'($urandom); exec_done = 1'($urandom);
      @(negedge clock);
      if (k == lat) break;
    end
    exc = (lat > MW);
    if (exc) begin
      m_epc = m_pc; m_cause = 2'd1;
    end else begin
      m_pc = m_pc + 4;
      n_chk++;
      if (state !== DECODE || decode_valid !== 1'b1 || ir !== word || pc !== m_pc || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL decode: state=%0d dv=%b ir=%h pc=%h, required state=2 dv=1 ir=%h pc=%h", state, decode_valid, ir, pc, word, m_pc);
      end
      illegal_op = ill; mem_ready = 1'($urandom); exec_done = 1'($urandom);
      overflow = 1'($urandom); branch_taken = 1'($urandom); branch_target = $urandom;
      @(negedge clock);
      if (ill) begin
        exc = 1; m_epc = m_pc - 4; m_cause = 2'd2;
      end else begin
        for (int e = 0; e <= elat; e++) begin
          n_chk++;
          if (state !== EXEC || decode_valid !== 1'b0 || mem_req !== 1'b0 || exc_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL exec[%0d]: state=%0d dv=%b req=%b, required state=3 dv=0 req=0", e, state, decode_valid, mem_req);
          end
          exec_done = (e == elat);
          overflow      = (e == elat) ? ovf : 1'($urandom);
          branch_taken  = (e == elat) ? br  : 1'($urandom);
          branch_target = (e == elat) ? tgt : $urandom;
          illegal_op = 1'($urandom); mem_ready = 1'($urandom);
          @(negedge clock);
        end
        if (ovf) begin
          exc = 1; m_epc = m_pc - 4; m_cause = 2'd3;
        end else if (br && tgt[1:0] != 2'b00) begin
          exc = 1; m_epc = m_pc - 4; m_cause = 2'd0;
        end else begin
          m_ret = m_ret + 1;
          if (br) m_pc = tgt;
        end
      end
    end
    if (exc) begin
      n_chk++;
      if (state !== EXCEPT || exc_pulse !== 1'b1 || cause !== m_cause || epc !== m_epc || retired !== m_ret) begin
        n_fail++;
        $display("FAIL except: state=%0d pulse=%b cause=%0d epc=%h ret=%0d, required 4 1 %0d %h %0d",
                 state, exc_pulse, cause, epc, retired, m_cause, m_epc, m_ret);
      end
      m_pc = EXC;
      mem_ready = 1'($urandom); illegal_op = 1'($urandom); exec_done = 1'($urandom);
      @(negedge clock);
    end
    n_chk++;
    if (pc !== m_pc || retired !== m_ret || epc !== m_epc || cause !== m_cause || exc_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL retire: pc=%h ret=%0d epc=%h cause=%0d, required %h %0d %h %0d", pc, retired, epc, cause, m_pc, m_ret, m_epc, m_cause);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_chk++;
    if (state !== FETCH || pc !== 32'h0 || ir !== 32'h0 || epc !== 32'h0 || cause !== 2'd0 || retired !== 32'h0 ||
        mem_req !== 1'b1 || mem_addr !== 32'h0 || decode_valid !== 1'b0 || exc_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d pc=%h ir=%h epc=%h cause=%0d ret=%0d req=%b addr=%h dv=%b pulse=%b, required all zero except req=1",
               state, pc, ir, epc, cause, retired, mem_req, mem_addr, decode_valid, exc_pulse);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    longint c0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (mem_addr !== 32'(4 * i)) begin
        n_fail++; $display("FAIL seq_addr[%0d]: got %h, required %h", i, mem_addr, 4 * i);
      end
      run_instr(0, 0, 0, 0, 32'h0, 0);
      n_chk++;
      if (retired !== 32'(i + 1)) begin
        n_fail++; $display("FAIL seq_retired[%0d]: got %0d, required %0d", i, retired, i + 1);
      end
    end
    n_chk++;
    if (cyc - c0 != 12) begin
      n_fail++; $display("FAIL seq_cycles: got %0d, required 12", cyc - c0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr(MW + 1, 0, 0, 0, 32'h0, 0);
    n_chk++;
    if (cause !== 2'd1 || epc !== 32'h0 || pc !== EXC) begin
      n_fail++; $display("FAIL timeout: cause=%0d epc=%h pc=%h, required 1 0 %h", cause, epc, pc, EXC);
    end
    run_instr(MW, 0, 0, 0, 32'h0, 0);
    n_chk++;
    if (retired !== 32'd1 || pc !== EXC + 4) begin
      n_fail++; $display("FAIL ready_wins: ret=%0d pc=%h, required 1 %h", retired, pc, EXC + 4);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(0, 0, 0, 0, 32'h0, 0);
    run_instr(2, 0, 0, 0, 32'h0, 1);
    run_instr(1, 1, 0, 0, 32'h0, 0);
    n_chk++;
    if (cause !== 2'd2 || epc !== 32'h8 || retired !== 32'd2) begin
      n_fail++; $display("FAIL illegal: cause=%0d epc=%h ret=%0d, required 2 8 2", cause, epc, retired);
    end
  endtask

  task automatic test_overflow();
    run_instr(0, 0, 1, 1, 32'h40, 1);
    n_chk++;
    if (cause !== 2'd3 || pc !== EXC || retired !== 32'd2) begin
      n_fail++; $display("FAIL overflow: cause=%0d pc=%h ret=%0d, required 3 %h 2", cause, pc, retired, EXC);
    end
  endtask

  task automatic test_branch();
    run_instr(1, 0, 0, 1, 32'h42, 0);
    n_chk++;
    if (cause !== 2'd0 || epc !== EXC || pc !== EXC) begin
      n_fail++; $display("FAIL align: cause=%0d epc=%h pc=%h, required 0 %h %h", cause, epc, pc, EXC, EXC);
    end
    run_instr(0, 0, 0, 1, 32'h40, 2);
    n_chk++;
    if (mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL branch: next addr %h, required 00000040", mem_addr);
    end
    run_instr(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    run_instr(0, 0, 0, 0, 32'h0, 0);
    n_chk++;
    if (mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL pc_wrap: next addr %h, required 00000000", mem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 0, 32'h0, 0);
    mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (state !== FETCH || pc !== 32'h0 || mem_addr !== 32'h0 || mem_req !== 1'b1 || retired !== 32'h0 ||
        ir !== 32'h0 || decode_valid !== 1'b0 || exc_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wait: state=%0d pc=%h addr=%h ret=%0d, required 0 0 0 0", state, pc, mem_addr, retired);
    end
    @(negedge clock); reset = 1'b0;
    model_reset();
    run_instr(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_random();
    int lat, elat;
    bit ill, ovf, br;
    logic [31:0] tgt;
    for (int n = 0; n < 60; n++) begin
      lat  = ($urandom_range(0, 9) == 0) ? MW + 1 : $urandom_range(0, MW);
      ill  = ($urandom_range(0, 9) == 0);
      ovf  = ($urandom_range(0, 9) == 0);
      br   = ($urandom_range(0, 2) == 0);
      tgt  = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      elat = $urandom_range(0, 3);
      run_instr(lat, ill, ovf, br, tgt, elat);
    end
  endtask

  initial begin
    mem_ready = 0; mem_rdata = 0; illegal_op = 0; exec_done = 0;
    overflow = 0; branch_taken = 0; branch_target = 0;
    @(negedge clock);
    test_reset();
    test_sequential();
    test_timeout();
    test_illegal();
    test_overflow();
    test_branch();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
